// File: rtl/seven_seg_display_ctrl.sv
// Scan controller for a 4-digit multiplexed seven-segment display with
// double-buffered load, frame-aligned commit, digit masking, LZB and blink.
module seven_seg_display_ctrl #(
    parameter int unsigned DWELL_CYCLES = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic        div_clock,
    input  logic        reset,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_value,
    input  logic [3:0]  load_mask,
    input  logic [3:0]  load_dp,
    input  logic        load_lzb,
    input  logic        blink_en,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam int unsigned BW = $clog2(2 * BLINK_FRAMES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

    typedef enum logic {
        GAP,
        ACTIVE
    } state_t;

    state_t        state, nxt_state;
    logic [1:0]    idx, nxt_idx;
    logic [DW-1:0] dwell, nxt_dwell;
    logic [BW-1:0] blink_cnt;

    logic [15:0] act_value, shd_value;
    logic [3:0]  act_mask, shd_mask;
    logic [3:0]  act_dp, shd_dp;
    logic        act_lzb, shd_lzb;
    logic        pending, nxt_pending;

    logic       last_dwell, frame_end, xfer, blink_dark, lit_next;
    logic [3:0] blank;
    logic [3:0] nib;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        last_dwell  = (dwell == DWELL_LAST);
        frame_end   = (state == ACTIVE) && last_dwell && (idx == 2'd3);
        xfer        = load_valid && load_ready;
        nxt_state   = state;
        nxt_idx     = idx;
        nxt_dwell   = dwell;
        if (state == GAP) begin
            nxt_state = ACTIVE;
            nxt_dwell = '0;
        end else if (last_dwell) begin
            nxt_state = GAP;
            nxt_idx   = idx + 2'd1;
            nxt_dwell = '0;
        end else begin
            nxt_dwell = dwell + 1'b1;
        end

        // Commit frees the shadow; a same-cycle transfer refills it for the next frame.
        if (frame_end && pending)
            nxt_pending = 1'b0;
        else if (xfer)
            nxt_pending = 1'b1;
        else
            nxt_pending = pending;

        blank[3] = act_lzb && (act_value[15:12] == 4'h0);
        blank[2] = blank[3] && (act_value[11:8] == 4'h0);
        blank[1] = blank[2] && (act_value[7:4] == 4'h0);
        blank[0] = 1'b0;

        // Counter wraps at 2*BLINK_FRAMES (a power of two), so the MSB marks the dark half.
        blink_dark = blink_en && blink_cnt[BW-1];
        nib        = act_value[{nxt_idx, 2'b00} +: 4];
        lit_next   = (nxt_state == ACTIVE) && act_mask[nxt_idx] && !blank[nxt_idx] && !blink_dark;
    end

    // Outputs are loaded from the next scan position so they align with the state registers.
    always_ff @(posedge div_clock) begin
        if (reset) begin
            state      <= GAP;
            idx        <= '0;
            dwell      <= '0;
            blink_cnt  <= '0;
            act_value  <= '0;
            act_mask   <= '0;
            act_dp     <= '0;
            act_lzb    <= 1'b0;
            shd_value  <= '0;
            shd_mask   <= '0;
            shd_dp     <= '0;
            shd_lzb    <= 1'b0;
            pending    <= 1'b0;
            load_ready <= 1'b1;
            frame_done <= 1'b0;
            anode      <= '1;
            seg        <= '1;
            dp         <= 1'b1;
        end else begin
            state <= nxt_state;
            idx   <= nxt_idx;
            dwell <= nxt_dwell;
            if (xfer) begin
                shd_value <= load_value;
                shd_mask  <= load_mask;
                shd_dp    <= load_dp;
                shd_lzb   <= load_lzb;
            end
            if (frame_end) begin
                blink_cnt <= blink_cnt + 1'b1;
                if (pending) begin
                    act_value <= shd_value;
                    act_mask  <= shd_mask;
                    act_dp    <= shd_dp;
                    act_lzb   <= shd_lzb;
                end
            end
            pending    <= nxt_pending;
            load_ready <= !nxt_pending;
            frame_done <= frame_end;
            anode      <= lit_next ? ~(4'b0001 << nxt_idx) : '1;
            seg        <= lit_next ? hex_to_seg(nib) : '1;
            dp         <= lit_next ? ~act_dp[nxt_idx] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// Directed bench for seven_seg_display_ctrl with DWELL_CYCLES=2, BLINK_FRAMES=2
// (12-cycle frame: GAP, 2x digit0, GAP, 2x digit1, GAP, 2x digit2, GAP, 2x digit3).
module tb_seven_seg_display_ctrl;

    logic        div_clock;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_value;
    logic [3:0]  load_mask;
    logic [3:0]  load_dp;
    logic        load_lzb;
    logic        blink_en;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    seven_seg_display_ctrl #(
        .DWELL_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .div_clock (div_clock),
        .reset     (reset),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_value(load_value),
        .load_mask (load_mask),
        .load_dp   (load_dp),
        .load_lzb  (load_lzb),
        .blink_en  (blink_en),
        .anode     (anode),
        .seg       (seg),
        .dp        (dp),
        .frame_done(frame_done)
    );

    initial div_clock = 1'b0;
    always #5 div_clock = ~div_clock;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  mask;
        logic [3:0]  dpin;
        logic        lzb;
        logic [27:0] segs;   // {d3, d2, d1, d0}
        logic [3:0]  lit;
        logic [3:0]  dpn;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge div_clock);
        #1;
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at frame position 0; checks all 12 cycles and returns at position 11.
    task automatic check_frame(input logic [27:0] segs, input logic [3:0] lit,
                               input logic [3:0] dpn, input string tag);
        int d;
        logic [3:0] ea;
        logic [6:0] es;
        logic       ed;
        for (int p = 0; p < 12; p++) begin
            if (p > 0) tick();
            d = p / 3;
            if ((p % 3) != 0 && lit[d]) begin
                ea = ~(4'b0001 << d);
                es = segs[d*7 +: 7];
                ed = dpn[d];
            end else begin
                ea = 4'hF;
                es = 7'h7F;
                ed = 1'b1;
            end
            chk({tag, "_anode"}, 32'(anode), 32'(ea));
            chk({tag, "_seg"}, 32'(seg), 32'(es));
            chk({tag, "_dp"}, 32'(dp), 32'(ed));
            if (p == 0) chk({tag, "_frame_done"}, 32'(frame_done), 32'(cyc != 0));
            else        chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        end
    endtask

    task automatic do_load(input vec_t v, input string tag);
        while ((cyc % 12) != 1) tick();
        chk({tag, "_ready_before"}, 32'(load_ready), 32'd1);
        load_value = v.value;
        load_mask  = v.mask;
        load_dp    = v.dpin;
        load_lzb   = v.lzb;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk({tag, "_ready_low"}, 32'(load_ready), 32'd0);
        while ((cyc % 12) != 0) begin
            if ((cyc % 12) == 11) chk({tag, "_ready_held"}, 32'(load_ready), 32'd0);
            tick();
        end
        chk({tag, "_ready_commit"}, 32'(load_ready), 32'd1);
        check_frame(v.segs, v.lit, v.dpn, tag);
    endtask

    initial begin
        vec_t v;
        logic [3:0] bl;

        vecs[0] = '{16'h1234, 4'hF, 4'h0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'hF};
        vecs[1] = '{16'h0070, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0011, 4'hF};
        vecs[2] = '{16'h0070, 4'hF, 4'h0, 1'b0, {7'h40, 7'h40, 7'h78, 7'h40}, 4'hF, 4'hF};
        vecs[3] = '{16'h0000, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b0001, 4'hF};
        vecs[4] = '{16'hBCDE, 4'b1010, 4'b1000, 1'b0, {7'h03, 7'h7F, 7'h21, 7'h7F}, 4'b1010, 4'b0111};
        vecs[5] = '{16'h0F08, 4'hF, 4'b0101, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h00}, 4'b0111, 4'b1010};
        vecs[6] = '{16'h6795, 4'hF, 4'hF, 1'b0, {7'h02, 7'h78, 7'h10, 7'h12}, 4'hF, 4'h0};
        vecs[7] = '{16'h0301, 4'hF, 4'h0, 1'b1, {7'h7F, 7'h30, 7'h40, 7'h79}, 4'b0111, 4'hF};
        vecs[8] = '{16'hEC00, 4'hF, 4'h0, 1'b1, {7'h06, 7'h46, 7'h40, 7'h40}, 4'hF, 4'hF};

        reset      = 1'b1;
        load_valid = 1'b0;
        load_value = '0;
        load_mask  = '0;
        load_dp    = '0;
        load_lzb   = 1'b0;
        blink_en   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;

        chk("reset_ready", 32'(load_ready), 32'd1);
        for (int i = 0; i < 30; i++) begin
            if (i > 0) tick();
            chk("idle_anode", 32'(anode), 32'hF);
            chk("idle_seg", 32'(seg), 32'h7F);
            chk("idle_dp", 32'(dp), 32'd1);
            chk("idle_frame_done", 32'(frame_done), 32'(cyc == 12 || cyc == 24));
        end

        for (int i = 0; i < 9; i++) do_load(vecs[i], $sformatf("vec%0d", i));

        // Offer a second value while busy: it must wait for load_ready.
        while ((cyc % 12) != 1) tick();
        load_value = 16'hAAAA;
        load_mask  = 4'hF;
        load_dp    = 4'h0;
        load_lzb   = 1'b0;
        load_valid = 1'b1;
        tick();
        load_value = 16'h5555;
        chk("busy_ready_low", 32'(load_ready), 32'd0);
        while ((cyc % 12) != 0) tick();
        chk("busy_ready_commit", 32'(load_ready), 32'd1);
        check_frame({4{7'h08}}, 4'hF, 4'hF, "busy_aaaa");
        tick();
        load_valid = 1'b0;
        check_frame({4{7'h12}}, 4'hF, 4'hF, "busy_5555");

        v = '{16'h8888, 4'hF, 4'hF, 1'b0, {4{7'h00}}, 4'hF, 4'h0};
        do_load(v, "blink_load");
        tick();
        blink_en = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bl = (((cyc / 12) % 4) >= 2) ? 4'h0 : 4'hF;
            check_frame({4{7'h00}}, bl, 4'h0, "blink_on");
            tick();
        end
        blink_en = 1'b0;
        for (int f = 0; f < 2; f++) begin
            check_frame({4{7'h00}}, 4'hF, 4'h0, "blink_off");
            tick();
        end

        // Reset during digit 2 with a load still pending.
        while ((cyc % 12) != 1) tick();
        load_value = 16'h1234;
        load_mask  = 4'hF;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        while ((cyc % 12) != 7) tick();
        chk("pre_reset_anode", 32'(anode), 32'hB);
        chk("pre_reset_ready", 32'(load_ready), 32'd0);
        reset = 1'b1;
        tick();
        chk("rst_anode", 32'(anode), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_ready", 32'(load_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset = 1'b0;
        cyc   = 0;
        check_frame({4{7'h7F}}, 4'h0, 4'hF, "post_rst0");
        tick();
        check_frame({4{7'h7F}}, 4'h0, 4'hF, "post_rst1");
        chk("post_rst_ready", 32'(load_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
